i2c_reg_bank: RTL and testbench

Parametrised I2C register bank that sits behind `i2cslave_controller_top` and replaces the fixed-map register file in the slave top level. It converts the controller's byte stream (start/stop/data_vld/r_w) into pointer-addressed, multi-byte register reads and writes. Write data is staged and committed atomically per register, with a per-register update strobe. Reads are snapshotted per register so status words cannot tear, and a read-only mask lets live status inputs share the map.

---
 rtl/i2c_reg_bank.sv | 113 +++++++++++
 tb/tb_i2c_reg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: pointer-addressed multi-byte register bank behind an I2C slave controller
//   clk, rst                      clock, asynchronous active-high reset
//   start, stop, data_vld, r_w    controller event pulses and transfer direction
//   rx_byte / tx_byte             received byte / byte returned for a read request
//   stretch_on                    holds SCL low while tx_byte is prepared
//   status_in                     live data for read-only registers
//   reg_out, reg_update           committed contents and per-register commit strobes
module i2c_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int REG_BYTES = 2,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            data_vld,
  input  logic                            r_w,
  input  logic [7:0]                      rx_byte,
  output logic [7:0]                      tx_byte,
  output logic                            stretch_on,
  input  logic [NUM_REGS*REG_BYTES*8-1:0] status_in,
  output logic [NUM_REGS*REG_BYTES*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]             reg_update
);
  localparam int W = REG_BYTES * 8;
  localparam logic [1:0] IDLE = 2'd0, PTR = 2'd1, WDATA = 2'd2, RDATA = 2'd3;
  logic [1:0] state, st;
  logic [7:0] ptr, ptr_inc, rd_byte;
  logic [2:0] byte_cnt, cnt;
  logic [W-1:0] stage, snap, src, cur, nstage, sh;
  logic [NUM_REGS*W-1:0] regs;
  logic hit, last, p1, p2;
  // st/cnt are the state and count as seen after a same-cycle start is applied
  always_comb begin
    st = start ? PTR : state;
    cnt = start ? 3'd0 : byte_cnt;
    src = '1;
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ptr == 8'(i)) begin
        hit = 1'b1;
        src = RO_MASK[i] ? status_in[i*W +: W] : regs[i*W +: W];
      end
    ptr_inc = hit ? (ptr == 8'(NUM_REGS - 1) ? 8'd0 : ptr + 8'd1) : ptr;
    last = cnt == 3'(REG_BYTES - 1);
    nstage = W'({stage, rx_byte});
    cur = cnt == 3'd0 ? src : snap;
    sh = cur >> (8 * (REG_BYTES - 1 - int'(cnt)));
    reg_out = regs;
    for (int i = 0; i < NUM_REGS; i++)
      if (RO_MASK[i]) reg_out[i*W +: W] = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      byte_cnt <= '0;
      stage <= '0;
      snap <= '0;
      regs <= RESET_VAL;
      reg_update <= '0;
      tx_byte <= '0;
      rd_byte <= '0;
      stretch_on <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      reg_update <= '0;
      p1 <= 1'b0;
      p2 <= p1;
      if (p2) begin
        tx_byte <= rd_byte;
        stretch_on <= 1'b0;
      end
      if (stop) begin
        state <= IDLE;
        byte_cnt <= '0;
        stage <= '0;
      end else begin
        if (start) begin
          state <= PTR;
          byte_cnt <= '0;
          stage <= '0;
        end
        if (data_vld && !r_w && st == PTR) begin
          ptr <= rx_byte;
          state <= WDATA;
        end else if (data_vld && !r_w && st == WDATA) begin
          stage <= last ? '0 : nstage;
          byte_cnt <= last ? 3'd0 : cnt + 3'd1;
          if (last) begin
            ptr <= ptr_inc;
            for (int i = 0; i < NUM_REGS; i++)
              if (ptr == 8'(i) && !RO_MASK[i]) begin
                regs[i*W +: W] <= nstage;
                reg_update[i] <= 1'b1;
              end
          end
        end else if (data_vld && r_w && (st == PTR || st == RDATA)) begin
          state <= RDATA;
          if (cnt == 3'd0) snap <= src;
          rd_byte <= sh[7:0];
          p1 <= 1'b1;
          stretch_on <= 1'b1;
          byte_cnt <= last ? 3'd0 : cnt + 3'd1;
          if (last) ptr <= ptr_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed self-checking bench for i2c_reg_bank (8 regs x 2 bytes, reg5 read-only)
module tb_i2c_reg_bank;
  localparam logic [127:0] RV = 128'h1727_1626_1525_1424_1323_1222_1121_1020;
  localparam logic [127:0] RO5 = 128'h0000_0000_FFFF_0000_0000_0000_0000_0000;
  logic clk = 0, rst = 1, start = 0, stop = 0, data_vld = 0, r_w = 0;
  logic [7:0] rx_byte = 0, tx_byte, b;
  logic stretch_on;
  logic [127:0] status_in = '0, reg_out, m;
  logic [7:0] reg_update;
  int checks = 0, errors = 0, sc, n;
  int upd_cnt [8];
  int upd_log [$];
  always #5 clk = ~clk;
  i2c_reg_bank #(.NUM_REGS(8), .REG_BYTES(2), .RO_MASK(8'h20), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld), .r_w(r_w),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .stretch_on(stretch_on), .status_in(status_in),
    .reg_out(reg_out), .reg_update(reg_update)
  );
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 8; i++)
        if (reg_update[i]) begin
          upd_cnt[i]++;
          upd_log.push_back(i);
        end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_start;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
  endtask
  task automatic do_stop;
    stop = 1;
    @(negedge clk);
    stop = 0;
    @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] v);
    data_vld = 1;
    r_w = 0;
    rx_byte = v;
    @(negedge clk);
    data_vld = 0;
    @(negedge clk);
  endtask
  task automatic rd(output logic [7:0] v, output int s);
    data_vld = 1;
    r_w = 1;
    @(negedge clk);
    data_vld = 0;
    r_w = 0;
    s = 0;
    repeat (4) begin
      if (stretch_on) s++;
      @(negedge clk);
    end
    v = tx_byte;
  endtask
  initial begin
    m = RV & ~RO5;
    @(negedge clk);
    chk("rst_reg_out", reg_out, m);
    chk("rst_update", reg_update, 8'h00);
    chk("rst_tx", tx_byte, 8'h00);
    chk("rst_stretch", stretch_on, 1'b0);
    rst = 0;
    @(negedge clk);
    do_start;
    wr(8'h03);
    wr(8'h12);
    data_vld = 1;
    rx_byte = 8'h34;
    @(negedge clk);
    data_vld = 0;
    m[63:48] = 16'h1234;
    chk("commit_strobe", reg_update, 8'h08);
    chk("commit_value", reg_out, m);
    @(negedge clk);
    chk("strobe_width", reg_update, 8'h00);
    do_stop;
    chk("t1_cnt3", upd_cnt[3], 1);
    chk("t1_total", upd_log.size(), 1);
    do_start;
    wr(8'h07);
    wr(8'hAA);
    wr(8'hBB);
    wr(8'hCC);
    wr(8'hDD);
    do_stop;
    m[127:112] = 16'hAABB;
    m[15:0] = 16'hCCDD;
    chk("wrap_regs", reg_out, m);
    chk("wrap_order", {upd_log.size(), upd_log[1], upd_log[2]}, {32'd3, 32'd7, 32'd0});
    do_start;
    wr(8'h02);
    wr(8'h55);
    do_stop;
    chk("partial_regs", reg_out, m);
    chk("partial_nostrobe", upd_log.size(), 3);
    do_start;
    wr(8'h02);
    do_start;
    rd(b, sc);
    chk("rd2_msb", b, 8'h12);
    chk("rd2_msb_stretch", sc, 2);
    rd(b, sc);
    chk("rd2_lsb", b, 8'h22);
    chk("rd2_lsb_stretch", sc, 2);
    do_stop;
    status_in[95:80] = 16'h0102;
    do_start;
    wr(8'h05);
    do_start;
    rd(b, sc);
    chk("ro_msb", b, 8'h01);
    status_in[95:80] = 16'hFFFF;
    rd(b, sc);
    chk("ro_snapshot_lsb", b, 8'h02);
    do_stop;
    do_start;
    wr(8'h05);
    wr(8'h99);
    wr(8'h99);
    do_stop;
    chk("ro_nostrobe", upd_cnt[5], 0);
    chk("ro_reg_out", reg_out, m);
    do_start;
    wr(8'h07);
    do_start;
    rd(b, sc);
    chk("rdwrap_0", b, 8'hAA);
    rd(b, sc);
    chk("rdwrap_1", b, 8'hBB);
    rd(b, sc);
    chk("rdwrap_2", b, 8'hCC);
    rd(b, sc);
    chk("rdwrap_3", b, 8'hDD);
    do_stop;
    start = 1;
    data_vld = 1;
    r_w = 0;
    rx_byte = 8'h03;
    @(negedge clk);
    start = 0;
    data_vld = 0;
    @(negedge clk);
    wr(8'h56);
    wr(8'h78);
    do_stop;
    m[63:48] = 16'h5678;
    chk("start_same_cycle", reg_out, m);
    chk("start_same_cnt3", upd_cnt[3], 2);
    n = upd_log.size();
    wr(8'h05);
    wr(8'h11);
    wr(8'h22);
    chk("idle_ignored", upd_log.size(), n);
    chk("idle_regs", reg_out, m);
    do_start;
    wr(8'h20);
    do_start;
    rd(b, sc);
    chk("inv_rd0", b, 8'hFF);
    rd(b, sc);
    chk("inv_rd1", b, 8'hFF);
    do_stop;
    do_start;
    wr(8'h20);
    wr(8'h11);
    wr(8'h22);
    do_stop;
    chk("inv_nostrobe", upd_log.size(), n);
    chk("inv_regs", reg_out, m);
    do_start;
    rd(b, sc);
    chk("inv_ptr_kept", b, 8'hFF);
    do_stop;
    do_start;
    wr(8'h04);
    wr(8'hAB);
    rst = 1;
    #1;
    m = RV & ~RO5;
    chk("midrst_regs", reg_out, m);
    chk("midrst_update", reg_update, 8'h00);
    chk("midrst_stretch", stretch_on, 1'b0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    wr(8'hCD);
    do_stop;
    chk("midrst_nocommit", upd_log.size(), n);
    chk("midrst_regs_after", reg_out, m);
    do_start;
    wr(8'h00);
    do_start;
    data_vld = 1;
    r_w = 1;
    @(negedge clk);
    data_vld = 0;
    r_w = 0;
    chk("stretch_rise", stretch_on, 1'b1);
    rst = 1;
    #1;
    chk("stretch_async_clr", stretch_on, 1'b0);
    chk("tx_async_clr", tx_byte, 8'h00);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
